// File: rtl/constraint_eval_pipe.sv
// constraint_eval_pipe: two-stage masked-compare constraint checker over a candidate stream; CONSTRAINT_STATS_EN builds the run counters.
module constraint_eval_pipe #(
  parameter int W = 64,
  parameter int NC = 11,
  parameter int CNT_W = 32,
  parameter int IW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_idx,
  input  logic [W-1:0]     cfg_mask,
  input  logic [W-1:0]     cfg_value,
  input  logic             cfg_en,
  input  logic             start,
  input  logic             mode_first,
  input  logic             cand_valid,
  output logic             cand_ready,
  input  logic [W-1:0]     cand_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_pass,
  output logic [NC-1:0]    res_fail_vec,
  output logic [W-1:0]     res_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] stat_tested,
  output logic [CNT_W-1:0] stat_passed
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_nx;
  logic [W-1:0] mask [NC];
  logic [W-1:0] value [NC];
  logic [NC-1:0] en, s1_fail, fail_nx;
  logic [W-1:0] s1_data;
  logic s1_valid, mode_q, adv, accept, hit, xfer, launch;
  assign adv = !res_valid || res_ready;
  assign accept = res_valid && res_ready;
  assign hit = accept && res_pass && mode_q && state == RUN;
  assign launch = start && state != RUN;
  assign cand_ready = state == RUN && adv && !hit;
  assign xfer = cand_valid && cand_ready;
  assign busy = state == RUN || s1_valid || res_valid;
  assign done = state == HALT;
  always_comb begin
    state_nx = launch ? RUN : (hit ? HALT : state);
  end
  always_comb begin
    fail_nx = '0;
    for (int i = 0; i < NC; i++) fail_nx[i] = en[i] && |((cand_data ^ value[i]) & mask[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mode_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) mode_q <= mode_first;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        mask[i] <= '0;
        value[i] <= '0;
      end
      en <= '0;
    end else if (cfg_we && state != RUN && int'(cfg_idx) < NC) begin
      mask[cfg_idx] <= cfg_mask;
      value[cfg_idx] <= cfg_value;
      en[cfg_idx] <= cfg_en;
    end
  end
  // an accepted first hit drops the younger candidate still in stage 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_fail <= '0;
      res_valid <= 1'b0;
      res_pass <= 1'b0;
      res_fail_vec <= '0;
      res_data <= '0;
    end else if (hit) begin
      s1_valid <= 1'b0;
      res_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= xfer;
      s1_data <= cand_data;
      s1_fail <= fail_nx;
      res_valid <= s1_valid;
      res_pass <= s1_valid && !(|s1_fail);
      res_fail_vec <= s1_fail;
      res_data <= s1_data;
    end
  end
`ifdef CONSTRAINT_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tested <= '0;
      stat_passed <= '0;
    end else if (launch) begin
      stat_tested <= '0;
      stat_passed <= '0;
    end else if (accept) begin
      if (!(&stat_tested)) stat_tested <= stat_tested + 1'b1;
      if (res_pass && !(&stat_passed)) stat_passed <= stat_passed + 1'b1;
    end
  end
`else
  assign stat_tested = '0;
  assign stat_passed = '0;
`endif
endmodule

// File: tb/tb_constraint_eval_pipe.sv
// tb_constraint_eval_pipe: directed scenarios for constraint_eval_pipe with a posedge result monitor.
module tb_constraint_eval_pipe;
  localparam int W = 64;
  localparam int NC = 11;
  localparam int CNT_W = 32;
`ifdef CONSTRAINT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic cfg_we = 0, cfg_en = 0, start = 0, mode_first = 0, cand_valid = 0, res_ready = 1;
  logic [3:0] cfg_idx = '0;
  logic [W-1:0] cfg_mask = '0, cfg_value = '0, cand_data = '0;
  logic cand_ready, res_valid, res_pass, busy, done;
  logic [NC-1:0] res_fail_vec;
  logic [W-1:0] res_data;
  logic [CNT_W-1:0] stat_tested, stat_passed;
  int vectors = 0, miscompares = 0;
  int cyc = 0, n_xfer = 0, first_xfer = 0, first_res = 0, last_res = 0;
  logic [W-1:0] src [$];
  logic [W-1:0] got_data [$];
  logic got_pass [$];
  logic [NC-1:0] got_fail [$];

  constraint_eval_pipe #(.W(W), .NC(NC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask),
    .cfg_value(cfg_value), .cfg_en(cfg_en), .start(start), .mode_first(mode_first),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_data(cand_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_pass(res_pass),
    .res_fail_vec(res_fail_vec), .res_data(res_data), .busy(busy), .done(done),
    .stat_tested(stat_tested), .stat_passed(stat_passed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cand_valid = src.size() > 0;
    cand_data = (src.size() > 0) ? src[0] : '0;
  end

  always @(posedge clk) begin
    if (cand_valid && cand_ready) begin
      if (n_xfer == 0) first_xfer = cyc;
      n_xfer++;
      if (src.size() > 0) void'(src.pop_front());
    end
    if (res_valid && res_ready) begin
      if (got_data.size() == 0) first_res = cyc;
      last_res = cyc;
      got_data.push_back(res_data);
      got_pass.push_back(res_pass);
      got_fail.push_back(res_fail_vec);
    end
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: got time limit, required finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_obs();
    got_data.delete(); got_pass.delete(); got_fail.delete();
    n_xfer = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; src.delete(); cand_valid = 0;
    tick(2);
    rst = 0;
    clear_obs();
  endtask

  task automatic cfg_write(input logic [3:0] idx, input logic [W-1:0] m, input logic [W-1:0] v, input logic e);
    cfg_we = 1; cfg_idx = idx; cfg_mask = m; cfg_value = v; cfg_en = e;
    tick(1);
    cfg_we = 0;
  endtask

  task automatic start_run(input logic mf);
    clear_obs();
    start = 1; mode_first = mf;
    tick(1);
    start = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && !done; k++) tick(1);
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wait_done got=%b exp=1", done); end
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    vectors++; if (cand_ready !== 1'b0) begin miscompares++; $display("FAIL rst_cand_ready got=%b exp=0", cand_ready); end
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++; $display("FAIL rst_busy_done got=%b exp=00", {busy, done}); end
    vectors++; if ({res_pass, res_fail_vec, res_data} !== '0) begin miscompares++; $display("FAIL rst_res_fields got=%b/%h/%h exp=0", res_pass, res_fail_vec, res_data); end
    vectors++; if ({stat_tested, stat_passed} !== '0) begin miscompares++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", stat_tested, stat_passed); end
    tick(2);
    rst = 0;
    tick(1);
    vectors++; if ({cand_ready, busy, done} !== 3'b000) begin miscompares++; $display("FAIL idle_after_rst got=%b exp=000", {cand_ready, busy, done}); end
  endtask

  task automatic test_all_pass();
    do_reset();
    res_ready = 1;
    start_run(0);
    for (int i = 0; i < 5; i++) src.push_back(64'hDEAD_BEEF_0000_0000 | 64'(i * 3 + 1));
    for (int k = 0; k < 60 && got_data.size() < 5; k++) tick(1);
    vectors++; if (got_data.size() !== 5) begin miscompares++; $display("FAIL allpass_count got=%0d exp=5", got_data.size()); end
    vectors++; if (first_res - first_xfer !== 2) begin miscompares++; $display("FAIL allpass_latency got=%0d exp=2", first_res - first_xfer); end
    vectors++; if (last_res - first_res !== 4) begin miscompares++; $display("FAIL allpass_throughput got=%0d exp=4", last_res - first_res); end
    for (int i = 0; i < 5 && i < got_data.size(); i++) begin
      vectors++; if (got_data[i] !== (64'hDEAD_BEEF_0000_0000 | 64'(i * 3 + 1))) begin miscompares++; $display("FAIL allpass_data[%0d] got=%h exp=%h", i, got_data[i], 64'hDEAD_BEEF_0000_0000 | 64'(i * 3 + 1)); end
      vectors++; if ({got_pass[i], got_fail[i]} !== {1'b1, 11'h000}) begin miscompares++; $display("FAIL allpass_flags[%0d] got=%b/%h exp=1/000", i, got_pass[i], got_fail[i]); end
    end
    vectors++; if ({busy, done} !== 2'b10) begin miscompares++; $display("FAIL allpass_status got=%b exp=10", {busy, done}); end
  endtask

  task automatic test_slot_match();
    logic [W-1:0] cd [4];
    logic ep [4];
    logic [NC-1:0] ef [4];
    cd = '{64'h12A, 64'h12B, 64'h8000_0000_0000_012A, 64'h8000_0000_0000_012B};
    ep = '{1'b1, 1'b0, 1'b0, 1'b0};
    ef = '{11'h000, 11'h008, 11'h400, 11'h408};
    do_reset();
    cfg_write(4'd3, 64'hFF, 64'h2A, 1'b1);
    cfg_write(4'd10, 64'h8000_0000_0000_0000, 64'h0, 1'b1);
    cfg_write(4'd15, '1, 64'h0, 1'b1);
    res_ready = 1;
    start_run(0);
    for (int i = 0; i < 4; i++) src.push_back(cd[i]);
    for (int k = 0; k < 60 && got_data.size() < 4; k++) tick(1);
    vectors++; if (got_data.size() !== 4) begin miscompares++; $display("FAIL slot_count got=%0d exp=4", got_data.size()); end
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      vectors++; if ({got_pass[i], got_fail[i], got_data[i]} !== {ep[i], ef[i], cd[i]}) begin miscompares++; $display("FAIL slot_result[%0d] got=%b/%h/%h exp=%b/%h/%h", i, got_pass[i], got_fail[i], got_data[i], ep[i], ef[i], cd[i]); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    res_ready = 0;
    start_run(0);
    src.push_back(64'h111); src.push_back(64'h222); src.push_back(64'h333);
    for (int k = 0; k < 20 && !res_valid; k++) tick(1);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      vectors++; if ({res_valid, cand_ready, res_pass, res_data} !== {1'b1, 1'b0, 1'b1, 64'h111}) begin miscompares++; $display("FAIL bp_hold[%0d] got=%b/%b/%b/%h exp=1/0/1/111", k, res_valid, cand_ready, res_pass, res_data); end
    end
    vectors++; if (n_xfer !== 2) begin miscompares++; $display("FAIL bp_inflight got=%0d exp=2", n_xfer); end
    res_ready = 1;
    for (int k = 0; k < 30 && got_data.size() < 3; k++) tick(1);
    tick(5);
    vectors++; if (got_data.size() !== 3) begin miscompares++; $display("FAIL bp_count got=%0d exp=3", got_data.size()); end
    for (int i = 0; i < 3 && i < got_data.size(); i++) begin
      vectors++; if (got_data[i] !== 64'(32'h111 * (i + 1))) begin miscompares++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_data[i], 64'(32'h111 * (i + 1))); end
    end
  endtask

  task automatic test_first_hit();
    do_reset();
    cfg_write(4'd0, 64'hF, 64'h5, 1'b1);
    res_ready = 1;
    start_run(1);
    src.push_back(64'h10); src.push_back(64'h25); src.push_back(64'h35); src.push_back(64'h45);
    wait_done();
    tick(3);
    vectors++; if (got_data.size() !== 2) begin miscompares++; $display("FAIL fh_count got=%0d exp=2", got_data.size()); end
    if (got_data.size() >= 2) begin
      vectors++; if ({got_data[0], got_pass[0], got_fail[0]} !== {64'h10, 1'b0, 11'h001}) begin miscompares++; $display("FAIL fh_first got=%h/%b/%h exp=10/0/001", got_data[0], got_pass[0], got_fail[0]); end
      vectors++; if ({got_data[1], got_pass[1], got_fail[1]} !== {64'h25, 1'b1, 11'h000}) begin miscompares++; $display("FAIL fh_second got=%h/%b/%h exp=25/1/000", got_data[1], got_pass[1], got_fail[1]); end
    end
    vectors++; if ({n_xfer, src.size()} !== {32'd3, 32'd1}) begin miscompares++; $display("FAIL fh_transfers got=%0d/%0d exp=3/1", n_xfer, src.size()); end
    vectors++; if ({done, busy, cand_ready, res_valid} !== 4'b1000) begin miscompares++; $display("FAIL fh_status got=%b exp=1000", {done, busy, cand_ready, res_valid}); end
    vectors++; if (stat_tested !== (STATS ? 32'd2 : 32'd0)) begin miscompares++; $display("FAIL fh_stat_tested got=%0d exp=%0d", stat_tested, STATS ? 2 : 0); end
    vectors++; if (stat_passed !== (STATS ? 32'd1 : 32'd0)) begin miscompares++; $display("FAIL fh_stat_passed got=%0d exp=%0d", stat_passed, STATS ? 1 : 0); end
    src.delete();
  endtask

  task automatic test_cfg_in_run();
    do_reset();
    cfg_write(4'd0, 64'hFF, 64'h11, 1'b1);
    res_ready = 1;
    start_run(1);
    cfg_write(4'd0, 64'hFF, 64'h22, 1'b1);
    src.push_back(64'h22); src.push_back(64'h11);
    wait_done();
    vectors++; if (got_data.size() !== 2) begin miscompares++; $display("FAIL cfgrun_count got=%0d exp=2", got_data.size()); end
    if (got_data.size() >= 2) begin
      vectors++; if ({got_pass[0], got_fail[0], got_pass[1]} !== {1'b0, 11'h001, 1'b1}) begin miscompares++; $display("FAIL cfgrun_ignored got=%b/%h/%b exp=0/001/1", got_pass[0], got_fail[0], got_pass[1]); end
    end
    cfg_write(4'd0, 64'hFF, 64'h22, 1'b1);
    start_run(1);
    src.push_back(64'h11); src.push_back(64'h22);
    wait_done();
    vectors++; if (got_data.size() !== 2) begin miscompares++; $display("FAIL cfghalt_count got=%0d exp=2", got_data.size()); end
    if (got_data.size() >= 2) begin
      vectors++; if ({got_data[0], got_pass[0], got_data[1], got_pass[1]} !== {64'h11, 1'b0, 64'h22, 1'b1}) begin miscompares++; $display("FAIL cfghalt_applied got=%h/%b/%h/%b exp=11/0/22/1", got_data[0], got_pass[0], got_data[1], got_pass[1]); end
    end
    vectors++; if ({stat_tested, stat_passed} !== (STATS ? {32'd2, 32'd1} : 64'd0)) begin miscompares++; $display("FAIL cfghalt_stats got=%0d/%0d exp=%0d/%0d", stat_tested, stat_passed, STATS ? 2 : 0, STATS ? 1 : 0); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    res_ready = 1;
    start_run(0);
    src.push_back(64'h77); src.push_back(64'h88);
    for (int k = 0; k < 20 && n_xfer < 2; k++) tick(1);
    vectors++; if ({n_xfer, res_valid, busy} !== {32'd2, 1'b1, 1'b1}) begin miscompares++; $display("FAIL mid_inflight got=%0d/%b/%b exp=2/1/1", n_xfer, res_valid, busy); end
    #2 rst = 1;
    #1;
    vectors++; if ({res_valid, busy, done, cand_ready} !== 4'b0000) begin miscompares++; $display("FAIL mid_rst_async got=%b exp=0000", {res_valid, busy, done, cand_ready}); end
    src.delete();
    tick(2);
    rst = 0;
    clear_obs();
    tick(6);
    vectors++; if (got_data.size() !== 0) begin miscompares++; $display("FAIL mid_stale_results got=%0d exp=0", got_data.size()); end
    vectors++; if ({res_valid, busy, cand_ready} !== 3'b000) begin miscompares++; $display("FAIL mid_idle got=%b exp=000", {res_valid, busy, cand_ready}); end
  endtask

  initial begin
    test_reset();
    test_all_pass();
    test_slot_match();
    test_backpressure();
    test_first_hit();
    test_cfg_in_run();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
